// File: rtl/mem_ctrl.sv
// mem_ctrl: responder side of the byte-serial memory interface.
//
// Serves word/half/byte requests from the IF stage (always word reads) and
// the MEM stage (reads or writes). Each request is moved over an 8-bit
// single-port RAM bus one byte per cycle. The RAM has 1-cycle read latency.
// Every accepted request ends with a single-cycle done pulse.
//
// Ports:
//   clk, rst      clock (rising edge); synchronous active-high reset
//   rdy           global ready; low pauses the controller
//   if_req_i      IF read request (level, held until if_done_o)
//   if_addr_i     IF byte address
//   if_done_o     IF done pulse; if_data_o valid
//   if_data_o     fetched word, byte0 in [7:0]
//   mem_req_i     MEM request (level, held until mem_done_o)
//   mem_we_i      1 = write, 0 = read
//   mem_size_i    00 byte, 01 half, 10/11 word
//   mem_addr_i    MEM byte address
//   mem_wdata_i   write data, byte k in [8k+7:8k]
//   mem_done_o    MEM done pulse; read data valid or write complete
//   mem_rdata_o   read data, zero-extended above the access size
//   ram_din_i     RAM read byte, valid one cycle after the address
//   ram_dout_o    RAM write byte
//   ram_addr_o    RAM byte address
//   ram_wr_o      RAM write strobe
//   busy_o        high whenever the controller is not idle
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state, state_n;
  logic                src_mem, src_mem_n;
  logic [ADDR_W-1:0]   req_addr, req_addr_n;
  logic [2:0]          req_nb, req_nb_n;
  logic [31:0]         req_wdata, req_wdata_n;
  logic [2:0]          cnt, cnt_n;
  logic [31:0]         rbuf, rbuf_n;
  logic [ADDR_W-1:0]   offset;

  logic                if_done_n, mem_done_n, ram_wr_n, busy_n;
  logic [31:0]         if_data_n, mem_rdata_n;
  logic [7:0]          ram_dout_n;
  logic [ADDR_W-1:0]   ram_addr_n;

  function automatic logic [2:0] size_to_nb(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // cnt counts edges since the request was (re)started. At edge j the
  // controller issues byte j (if j < N); for reads it also captures the byte
  // issued two edges earlier, since RAM data appears one cycle after the address.
  // Dropping rdy clears cnt, so the next ready edge restarts from byte 0.
  always_comb begin
    state_n     = state;
    src_mem_n   = src_mem;
    req_addr_n  = req_addr;
    req_nb_n    = req_nb;
    req_wdata_n = req_wdata;
    cnt_n       = cnt;
    rbuf_n      = rbuf;
    ram_addr_n  = ram_addr_o;
    ram_dout_n  = ram_dout_o;
    ram_wr_n    = 1'b0;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    if_data_n   = if_data_o;
    mem_rdata_n = mem_rdata_o;
    offset      = ADDR_W'(cnt);

    case (state)
      IDLE: begin
        if (rdy) begin
          if (mem_req_i) begin
            src_mem_n   = 1'b1;
            req_addr_n  = mem_addr_i;
            req_nb_n    = size_to_nb(mem_size_i);
            req_wdata_n = mem_wdata_i;
            rbuf_n      = '0;
            cnt_n       = 3'd1;
            ram_addr_n  = mem_addr_i;
            if (mem_we_i) begin
              ram_dout_n = mem_wdata_i[7:0];
              ram_wr_n   = 1'b1;
              state_n    = WRITE;
            end else begin
              state_n = READ;
            end
          end else if (if_req_i) begin
            src_mem_n  = 1'b0;
            req_addr_n = if_addr_i;
            req_nb_n   = 3'd4;
            rbuf_n     = '0;
            cnt_n      = 3'd1;
            ram_addr_n = if_addr_i;
            state_n    = READ;
          end
        end
      end

      READ: begin
        if (!rdy) begin
          cnt_n = '0;
        end else begin
          if (cnt < req_nb) begin
            ram_addr_n = req_addr + offset;
          end
          // cnt values 2..5 map onto byte lanes 0..3 through their low bits.
          if (cnt >= 3'd2) begin
            case (cnt[1:0])
              2'd2: rbuf_n[7:0]   = ram_din_i;
              2'd3: rbuf_n[15:8]  = ram_din_i;
              2'd0: rbuf_n[23:16] = ram_din_i;
              2'd1: rbuf_n[31:24] = ram_din_i;
            endcase
          end
          if (cnt == req_nb + 3'd1) begin
            state_n = DONE;
            if (src_mem) begin
              mem_done_n  = 1'b1;
              mem_rdata_n = rbuf_n;
            end else begin
              if_done_n = 1'b1;
              if_data_n = rbuf_n;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end

      WRITE: begin
        if (!rdy) begin
          cnt_n = '0;
        end else if (cnt < req_nb) begin
          ram_addr_n = req_addr + offset;
          ram_wr_n   = 1'b1;
          cnt_n      = cnt + 3'd1;
          case (cnt[1:0])
            2'd0: ram_dout_n = req_wdata[7:0];
            2'd1: ram_dout_n = req_wdata[15:8];
            2'd2: ram_dout_n = req_wdata[23:16];
            2'd3: ram_dout_n = req_wdata[31:24];
          endcase
        end else begin
          mem_done_n = 1'b1;
          state_n    = DONE;
        end
      end

      // The edge leaving DONE never accepts a request, leaving a one-cycle
      // bubble in which requesters drop req.
      DONE: begin
        if (rdy) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      src_mem     <= 1'b0;
      req_addr    <= '0;
      req_nb      <= '0;
      req_wdata   <= '0;
      cnt         <= '0;
      rbuf        <= '0;
      ram_addr_o  <= '0;
      ram_dout_o  <= '0;
      ram_wr_o    <= 1'b0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      if_data_o   <= '0;
      mem_rdata_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      src_mem     <= src_mem_n;
      req_addr    <= req_addr_n;
      req_nb      <= req_nb_n;
      req_wdata   <= req_wdata_n;
      cnt         <= cnt_n;
      rbuf        <= rbuf_n;
      ram_addr_o  <= ram_addr_n;
      ram_dout_o  <= ram_dout_n;
      ram_wr_o    <= ram_wr_n;
      if_done_o   <= if_done_n;
      mem_done_o  <= mem_done_n;
      if_data_o   <= if_data_n;
      mem_rdata_o <= mem_rdata_n;
      busy_o      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl.
//
// A byte-wide RAM model with 1-cycle read latency sits on the RAM pins. A
// separate golden byte memory is updated whenever a write request completes.
// Read results, latencies, bus address/data sequences and final RAM contents
// are checked against values computed from the golden memory and the
// request parameters.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_done_o;
  logic [31:0] if_data_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic        busy_o;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_done_o  (if_done_o),
    .if_data_o  (if_data_o),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_size_i (mem_size_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_done_o (mem_done_o),
    .mem_rdata_o(mem_rdata_o),
    .ram_din_i  (ram_din_i),
    .ram_dout_o (ram_dout_o),
    .ram_addr_o (ram_addr_o),
    .ram_wr_o   (ram_wr_o),
    .busy_o     (busy_o)
  );

  logic [7:0]  ram_mem  [logic [31:0]];
  logic [7:0]  gold_mem [logic [31:0]];
  logic [7:0]  ram_q = 8'h00;
  assign ram_din_i = ram_q;

  int          checks_done = 0;
  int          fails = 0;
  logic [31:0] addr_trace[$];
  logic [7:0]  dout_trace[$];
  bit          wr_trace[$];
  int          pause_at = 0;
  int          pause_len = 0;
  logic [31:0] last_if_data = 32'h0;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    if (gold_mem.exists(a)) return gold_mem[a];
    return init_byte(a);
  endfunction

  function automatic int bytes_of(input bit is_mem, input logic [1:0] size);
    if (!is_mem) return 4;
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  // RAM model: registered read of the current address; writes land on the edge.
  always @(posedge clk) begin
    ram_q <= ram_rd(ram_addr_o);
    if (ram_wr_o) ram_mem[ram_addr_o] = ram_dout_o;
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram_mem[a]  = d;
    gold_mem[a] = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_done++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit is_mem, input bit we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (is_mem) begin
      mem_req_i   = 1'b1;
      mem_we_i    = we;
      mem_size_i  = size;
      mem_addr_i  = addr;
      mem_wdata_i = wdata;
    end else begin
      if_req_i  = 1'b1;
      if_addr_i = addr;
    end
  endtask

  // Waits (bounded) for the done pulse of one port, tracing the RAM bus at
  // every negedge and driving an optional rdy pause. lat is the number of
  // negedges from the first one after the accepting edge up to the done.
  task automatic wait_done(input bit is_mem, output int lat, output logic [31:0] data);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    data = 32'h0;
    addr_trace.delete();
    dout_trace.delete();
    wr_trace.delete();
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      addr_trace.push_back(ram_addr_o);
      dout_trace.push_back(ram_dout_o);
      wr_trace.push_back(ram_wr_o);
      if (pause_at != 0 && i > pause_at && i <= pause_at + pause_len)
        checkOutput("wr_in_pause", 32'(ram_wr_o), 32'h0);
      if (is_mem ? mem_done_o : if_done_o) begin
        seen = 1'b1;
        lat  = i;
        data = is_mem ? mem_rdata_o : if_data_o;
      end else begin
        if (pause_at != 0 && i == pause_at) rdy = 1'b0;
        if (pause_at != 0 && i == pause_at + pause_len) rdy = 1'b1;
      end
    end
    rdy = 1'b1;
    checkOutput("done_seen", 32'(seen), 32'h1);
    if (seen) begin
      checkOutput("busy_at_done", 32'(busy_o), 32'h1);
      if (is_mem) mem_req_i = 1'b0;
      else        if_req_i  = 1'b0;
      @(negedge clk);
      checkOutput("done_width", 32'(is_mem ? mem_done_o : if_done_o), 32'h0);
      checkOutput("busy_after", 32'(busy_o), 32'h0);
    end else begin
      mem_req_i = 1'b0;
      if_req_i  = 1'b0;
    end
  endtask

  // Checks one finished request against the golden model. Byte k is issued
  // (address on the bus) at trace index base0+k, where base0 is the number of
  // negedges consumed before the final (re)start.
  task automatic check_result(input bit is_mem, input bit we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int lat, input logic [31:0] data);
    int          n;
    int          base0;
    int          wr_cnt;
    logic [31:0] exp;
    n     = bytes_of(is_mem, size);
    base0 = (pause_at != 0) ? pause_at + pause_len : 0;
    checkOutput("latency", 32'(lat), 32'(base0 + (we ? n + 1 : n + 2)));
    for (int k = 0; k < n; k++) begin
      if (addr_trace.size() > base0 + k) begin
        checkOutput("bus_addr", addr_trace[base0 + k], addr + 32'(k));
        if (we) checkOutput("bus_dout", 32'(dout_trace[base0 + k]), 32'(wdata[8*k +: 8]));
      end
    end
    wr_cnt = 0;
    foreach (wr_trace[i]) if (wr_trace[i]) wr_cnt++;
    checkOutput("wr_cycles", 32'(wr_cnt), we ? 32'(pause_at + n) : 32'h0);
    if (we) begin
      for (int k = 0; k < n; k++) gold_mem[addr + 32'(k)] = wdata[8*k +: 8];
    end else begin
      exp = 32'h0;
      for (int k = 0; k < n; k++) exp[8*k +: 8] = gold_rd(addr + 32'(k));
      checkOutput(is_mem ? "mem_rdata" : "if_data", data, exp);
    end
    if (is_mem) checkOutput("if_data_hold", if_data_o, last_if_data);
    else        last_if_data = data;
  endtask

  task automatic do_req(input bit is_mem, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int          lat;
    logic [31:0] data;
    applyStimulus(is_mem, we, size, addr, wdata);
    wait_done(is_mem, lat, data);
    check_result(is_mem, we, size, addr, wdata, lat, data);
    pause_at  = 0;
    pause_len = 0;
  endtask

  initial begin
    int          lat;
    logic [31:0] data;
    bit          is_mem;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    int          n;

    rst = 1'b1; rdy = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0; mem_addr_i = '0; mem_wdata_i = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    checkOutput("rst_wr", 32'(ram_wr_o), 32'h0);
    checkOutput("rst_addr", ram_addr_o, 32'h0);
    checkOutput("rst_if_data", if_data_o, 32'h0);
    checkOutput("rst_mem_rdata", mem_rdata_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // IF word fetch.
    for (int k = 0; k < 4; k++) preload(32'h10 + 32'(k), 8'h10 + 8'(k));
    do_req(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
    checkOutput("t1_word", last_if_data, 32'h13121110);

    // Store word then load one byte back.
    do_req(1'b1, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 2'b00, 32'h102, 32'h0);
    checkOutput("t2_lbu", mem_rdata_o, 32'h000000AD);

    // Simultaneous IF and MEM requests: MEM first, IF two edges after its done.
    preload(32'h200, 8'h34);
    preload(32'h201, 8'h12);
    applyStimulus(1'b1, 1'b0, 2'b01, 32'h200, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b10, 32'h40, 32'h0);
    wait_done(1'b1, lat, data);
    check_result(1'b1, 1'b0, 2'b01, 32'h200, 32'h0, lat, data);
    checkOutput("t3_lh", data, 32'h00001234);
    wait_done(1'b0, lat, data);
    check_result(1'b0, 1'b0, 2'b10, 32'h40, 32'h0, lat, data);

    // Word read across the top of the address space.
    preload(32'hFFFFFFFE, 8'hA1);
    preload(32'hFFFFFFFF, 8'hB2);
    preload(32'h00000000, 8'hC3);
    preload(32'h00000001, 8'hD4);
    do_req(1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0);
    checkOutput("t4_wrap", mem_rdata_o, 32'hD4C3B2A1);

    // Store word with a three-cycle rdy pause after two bytes.
    pause_at  = 2;
    pause_len = 3;
    do_req(1'b1, 1'b1, 2'b10, 32'h300, 32'hCAFEF00D);
    do_req(1'b1, 1'b0, 2'b10, 32'h300, 32'h0);
    checkOutput("t5_readback", mem_rdata_o, 32'hCAFEF00D);

    // Reset in the middle of a word fetch.
    applyStimulus(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    if_req_i = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy", 32'(busy_o), 32'h0);
    checkOutput("t6_wr", 32'(ram_wr_o), 32'h0);
    checkOutput("t6_done", 32'(if_done_o), 32'h0);
    checkOutput("t6_if_data", if_data_o, 32'h0);
    checkOutput("t6_mem_rdata", mem_rdata_o, 32'h0);
    rst = 1'b0;
    last_if_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("t6_no_done", 32'(if_done_o), 32'h0);
    end
    do_req(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);

    // Randomized mix of requests, some with rdy pauses.
    for (int it = 0; it < 40; it++) begin
      is_mem = ($urandom_range(0, 3) != 0);
      we     = is_mem && ($urandom_range(0, 1) == 1);
      size   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 5));
      else                           addr = 32'h400 + 32'($urandom_range(0, 31));
      n = bytes_of(is_mem, size);
      if ($urandom_range(0, 3) == 0) begin
        pause_at  = $urandom_range(1, n);
        pause_len = $urandom_range(1, 4);
      end
      do_req(is_mem, we, size, addr, $urandom);
    end

    foreach (gold_mem[a]) checkOutput("ram_contents", 32'(ram_rd(a)), 32'(gold_mem[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fails);
    $finish;
  end

endmodule
